// File: rtl/csa_accum_pipe.sv
// csa_accum_pipe: two-stage packet accumulator.
//   S1 compresses N unsigned W-bit operands per beat into carry-save sum/carry
//   vectors (3:2 compressors only, no carry-propagate adder).
//   S2 resolves the vectors with one adder into an S-bit accumulator and
//   publishes the packet total on the last beat.
// Optional feature: define CSA_ACCUM_OVF_EN to build a sticky per-packet
// overflow flag on ovf; without it ovf is tied low.
//
// Handshake (valid/ready): a beat transfers on a rising edge where
// in_valid && in_ready; a result transfers where out_valid && out_ready.
// in_ready depends only on out_valid/out_ready (never on in_valid), and a
// held result (out_valid && !out_ready) keeps sum/ovf stable and freezes the
// whole pipeline.
module csa_accum_pipe #(
  parameter int N = 9,
  parameter int W = 4,
  parameter int E = 3,
  parameter int A = 4,
  localparam int S = W + E + A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [W*N-1:0]   a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S-1:0]     sum,
  output logic             ovf
);

  // Carry-save vectors are sized so a full beat total is exact even when E
  // is configured below clog2(N); the beat value then never aliases.
  localparam int EB = (E > $clog2(N)) ? E : $clog2(N);
  localparam int VW = W + EB;

  logic          w_stall;
  logic [VW-1:0] w_csa_s;
  logic [VW-1:0] w_csa_c;
  logic [VW-1:0] w_op;
  logic [VW-1:0] w_xor;
  logic [VW-1:0] w_beat;
  logic [S-1:0]  w_beat_ext;
  logic [S-1:0]  w_acc_next;

  logic          r_s1_valid;
  logic          r_s1_last;
  logic [VW-1:0] r_s1_sum;
  logic [VW-1:0] r_s1_carry;
  logic [S-1:0]  r_acc;
  logic [S-1:0]  r_sum;
  logic          r_out_valid;

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;

  // 3:2 compressor chain: fold each further operand into the (sum, carry) pair.
  always_comb begin
    w_op    = '0;
    w_xor   = '0;
    w_csa_s = VW'(a[W-1:0]);
    w_csa_c = VW'(a[2*W-1:W]);
    for (int k = 2; k < N; k++) begin
      w_op    = VW'(a[k*W +: W]);
      w_xor   = w_csa_s ^ w_csa_c ^ w_op;
      w_csa_c = ((w_csa_s & w_csa_c) | (w_csa_s & w_op) | (w_csa_c & w_op)) << 1;
      w_csa_s = w_xor;
    end
  end

  // Beat value resolved at vector width, then zero-extended to the accumulator.
  assign w_beat     = r_s1_sum + r_s1_carry;
  assign w_beat_ext = S'(w_beat);

`ifdef CSA_ACCUM_OVF_EN
  logic [S:0] w_add;
  logic       r_ovf_acc;
  logic       r_ovf;

  assign w_add      = {1'b0, r_acc} + {1'b0, w_beat_ext};
  assign w_acc_next = w_add[S-1:0];
  assign ovf        = r_ovf;

  // Sticky carry-out tracker; published with the packet total, cleared with acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_acc <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (!w_stall && r_s1_valid) begin
      if (r_s1_last) begin
        r_ovf     <= r_ovf_acc | w_add[S];
        r_ovf_acc <= 1'b0;
      end else begin
        r_ovf_acc <= r_ovf_acc | w_add[S];
      end
    end
  end
`else
  assign w_acc_next = r_acc + w_beat_ext;
  assign ovf        = 1'b0;
`endif

  // S1 register: capture compressed vectors of the beat offered this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_carry <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_valid & in_last;
      r_s1_sum   <= w_csa_s;
      r_s1_carry <= w_csa_c;
    end
  end

  // S2 accumulator: add each beat, restart from zero after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (!w_stall && r_s1_valid) begin
      r_acc <= r_s1_last ? '0 : w_acc_next;
    end
  end

  // Result register: load on a last beat, otherwise drop once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      if (r_s1_valid && r_s1_last) begin
        r_sum       <= w_acc_next;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Testbench for csa_accum_pipe (N=9, W=4, E=3, A=4, S=11).
// Compile with +define+CSA_ACCUM_OVF_EN to check the overflow flag build.
module tb_csa_accum_pipe;

  localparam int N  = 9;
  localparam int W  = 4;
  localparam int E  = 3;
  localparam int A  = 4;
  localparam int S  = W + E + A;
  localparam int NW = N * W;
  localparam int N_RAND = 1200;

`ifdef CSA_ACCUM_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [NW-1:0] a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [S-1:0]  sum;
  logic          ovf;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [S-1:0]  exp_q[$];
  logic          exp_ovf_q[$];
  longint        model_total = 0;
  logic          ready_rand = 1'b0;
  logic          ready_val = 1'b1;
  logic [S-1:0]  e_sum;
  logic          e_ovf;
  logic [NW-1:0] all_f;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  csa_accum_pipe #(.N(N), .W(W), .E(E), .A(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  // Consumer: random or fixed out_ready, updated after the input driver.
  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_unexpected: got sum=%0d ovf=%b, expected no result", sum, ovf);
      end else begin
        e_sum = exp_q.pop_front();
        e_ovf = exp_ovf_q.pop_front();
        if (sum !== e_sum || ovf !== e_ovf)
          $display("FAIL out_result: got sum=%0d ovf=%b, expected sum=%0d ovf=%b",
                   sum, ovf, e_sum, e_ovf);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_ovf_q.delete();
    model_total = 0;
  endtask

  // Offer one beat until accepted, then update the reference model.
  task automatic send_beat(input logic [NW-1:0] ops, input logic last);
    int   guard;
    logic seen;
    int   bsum;
    guard    = 0;
    seen     = 1'b0;
    in_valid = 1'b1;
    a        = ops;
    in_last  = last;
    while (!seen && guard < 2000) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!seen) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, expected 1", guard);
    end else begin
      bsum = 0;
      for (int k = 0; k < N; k++) bsum += int'(ops[k*W +: W]);
      model_total += bsum;
      if (last) begin
        exp_q.push_back(S'(model_total));
        exp_ovf_q.push_back(OVF_EN && (model_total > longint'((1 << S) - 1)));
        model_total = 0;
      end
    end
  endtask

  task automatic wait_out();
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (sum !== '0) $display("FAIL reset_sum: got %0d expected 0", sum);
    else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    clear_model();
  endtask

  task automatic test_single_beat();
    ready_val = 1'b1;
    send_beat(all_f, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_early: out_valid got %b expected 0", out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL single_latency: out_valid got %b expected 1", out_valid);
    else n_pass++;
    n_checks++;
    if (sum !== S'(135) || ovf !== 1'b0)
      $display("FAIL single_sum: got sum=%0d ovf=%b expected sum=135 ovf=0", sum, ovf);
    else n_pass++;
    drain();
  endtask

  task automatic test_gap();
    send_beat(all_f, 1'b0);
    idle(3);
    send_beat(all_f, 1'b1);
    wait_out();
    n_checks++;
    if (out_valid !== 1'b1 || sum !== S'(270))
      $display("FAIL gap_sum: got valid=%b sum=%0d expected valid=1 sum=270", out_valid, sum);
    else n_pass++;
    drain();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) send_beat(all_f, i == 15);
    wait_out();
    n_checks++;
    if (out_valid !== 1'b1 || sum !== S'(112) || ovf !== OVF_EN)
      $display("FAIL wrap_sum: got valid=%b sum=%0d ovf=%b expected valid=1 sum=112 ovf=%b",
               out_valid, sum, ovf, OVF_EN);
    else n_pass++;
    drain();
  endtask

  task automatic test_stall();
    ready_val = 1'b0;
    send_beat(all_f, 1'b1);
    send_beat(all_f, 1'b0);
    in_valid = 1'b1;
    a        = all_f;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || sum !== S'(135))
        $display("FAIL stall_hold: cycle %0d got valid=%b sum=%0d expected valid=1 sum=135",
                 i, out_valid, sum);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    ready_val = 1'b1;
    send_beat(all_f, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] ops;
    ready_val = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(all_f, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    else n_pass++;
    for (int k = 0; k < N; k++) ops[k*W +: W] = W'(k + 1);
    send_beat(ops, 1'b1);
    wait_out();
    n_checks++;
    if (out_valid !== 1'b1 || sum !== S'(45))
      $display("FAIL midrst_sum: got valid=%b sum=%0d expected valid=1 sum=45", out_valid, sum);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [NW-1:0] ops;
    int nb;
    ready_rand = 1'b1;
    for (int p = 0; p < N_RAND; p++) begin
      nb = $urandom_range(1, 20);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) ops = all_f;
        else for (int k = 0; k < N; k++) ops[k*W +: W] = W'($urandom_range(0, 15));
        send_beat(ops, b == nb - 1);
      end
    end
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    all_f = '1;
    test_reset();
    test_single_beat();
    test_gap();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover: got %0d pending results expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
